// File: rtl/btn_debounce_array_if.sv
// Pin-side bundle for btn_debounce_array: raw pins and game tick in, debounced level and event pulses out.
// `release` is a reserved word, so the release pulse is carried on `rel`.
interface btn_debounce_array_if #(
  parameter int N_CH = 5
);
  logic [N_CH-1:0] raw;
  logic            tick;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] rel;
  logic [N_CH-1:0] rpt;

  modport master (
    output raw, tick,
    input  level, press, rel, rpt
  );

  modport slave (
    input  raw, tick,
    output level, press, rel, rpt
  );
endinterface

// File: rtl/btn_debounce_array.sv
// Multi-channel push-button debouncer: two-flop synchroniser, saturating stability counter,
// committed level with press/release pulses, and a tick-driven auto-repeat FSM per channel.
module btn_debounce_array #(
  parameter int              N_CH       = 5,
  parameter int              CNT_MAX    = 250000,
  parameter int              HOLD_TICKS = 16,
  parameter int              RPT_TICKS  = 6,
  parameter logic [N_CH-1:0] INV_MASK   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  btn_debounce_array_if.slave  bus
);

  localparam int CW   = $clog2(CNT_MAX + 1);
  localparam int RMAX = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic          s_s;
    logic          sync1_r;
    logic          sync2_r;
    logic          cand_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          press_r;
    logic          rel_r;
    logic          rpt_r;
    rpt_state_e    state_r;
    rpt_state_e    state_nx_s;
    logic [RW-1:0] rc_r;
    logic [RW-1:0] rc_nx_s;
    logic [RW-1:0] rc_inc_s;
    logic          commit_s;
    logic          press_s;
    logic          rel_s;
    logic          rpt_s;

    assign s_s      = bus.raw[g] ^ INV_MASK[g];
    assign commit_s = (sync2_r == cand_r) && (cnt_r == CW'(CNT_MAX)) && (cand_r != level_r);
    assign press_s  = commit_s & cand_r;
    assign rel_s    = commit_s & ~cand_r;
    assign rc_inc_s = rc_r + RW'(1);

    // Release wins over press and tick; a tick coincident with the press commit is not counted.
    always_comb begin
      state_nx_s = state_r;
      rc_nx_s    = rc_r;
      rpt_s      = 1'b0;
      if (rel_s) begin
        state_nx_s = ST_IDLE;
        rc_nx_s    = '0;
      end else if (press_s) begin
        state_nx_s = ST_DELAY;
        rc_nx_s    = '0;
        rpt_s      = 1'b1;
      end else begin
        case (state_r)
          ST_DELAY: begin
            if (bus.tick) begin
              if (rc_inc_s == RW'(HOLD_TICKS)) begin
                state_nx_s = ST_REPEAT;
                rc_nx_s    = '0;
                rpt_s      = 1'b1;
              end else begin
                rc_nx_s = rc_inc_s;
              end
            end else begin
              rc_nx_s = rc_r;
            end
          end
          ST_REPEAT: begin
            if (bus.tick) begin
              if (rc_inc_s == RW'(RPT_TICKS)) begin
                rc_nx_s = '0;
                rpt_s   = 1'b1;
              end else begin
                rc_nx_s = rc_inc_s;
              end
            end else begin
              rc_nx_s = rc_r;
            end
          end
          ST_IDLE: begin
            state_nx_s = ST_IDLE;
          end
          default: begin
            state_nx_s = ST_IDLE;
            rc_nx_s    = '0;
          end
        endcase
      end
    end

    // Synchroniser, stability counter, committed level and registered event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_r <= 1'b0;
        sync2_r <= 1'b0;
        cand_r  <= 1'b0;
        cnt_r   <= '0;
        level_r <= 1'b0;
        press_r <= 1'b0;
        rel_r   <= 1'b0;
        rpt_r   <= 1'b0;
        state_r <= ST_IDLE;
        rc_r    <= '0;
      end else begin
        sync1_r <= s_s;
        sync2_r <= sync1_r;
        if (sync2_r != cand_r) begin
          cand_r <= sync2_r;
          cnt_r  <= '0;
        end else if (cnt_r != CW'(CNT_MAX)) begin
          cnt_r <= cnt_r + CW'(1);
        end else begin
          cnt_r <= cnt_r;
        end
        if (commit_s) begin
          level_r <= cand_r;
        end else begin
          level_r <= level_r;
        end
        press_r <= press_s;
        rel_r   <= rel_s;
        rpt_r   <= rpt_s;
        state_r <= state_nx_s;
        rc_r    <= rc_nx_s;
      end
    end

    assign bus.level[g] = level_r;
    assign bus.press[g] = press_r;
    assign bus.rel[g]   = rel_r;
    assign bus.rpt[g]   = rpt_r;
  end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Directed bench for btn_debounce_array: expected pulses are queued with their due cycle when
// stimulus is driven, then every cycle the full output vector is compared against the queue.
module tb_btn_debounce_array;

  localparam int              N_CH       = 2;
  localparam int              CNT_MAX    = 4;
  localparam int              HOLD_TICKS = 3;
  localparam int              RPT_TICKS  = 2;
  localparam logic [N_CH-1:0] INV_MASK   = 2'b10;
  // Drive-to-output distance: sampled on the next edge, then CNT_MAX+3 edges later.
  localparam int              DLY        = CNT_MAX + 4;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_RPT   = 2;

  typedef struct {
    int at;
    int ch;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [N_CH-1:0] exp_level = 2'b00;
  ev_t  q[$];

  always #5 clk = ~clk;

  btn_debounce_array_if #(.N_CH(N_CH)) bif ();

  btn_debounce_array #(
    .N_CH       (N_CH),
    .CNT_MAX    (CNT_MAX),
    .HOLD_TICKS (HOLD_TICKS),
    .RPT_TICKS  (RPT_TICKS),
    .INV_MASK   (INV_MASK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  task automatic push(input int dly, input int ch, input int kind);
    ev_t e;
    e.at   = cyc + dly;
    e.ch   = ch;
    e.kind = kind;
    q.push_back(e);
  endtask

  task automatic check_outputs();
    logic [N_CH-1:0] ep;
    logic [N_CH-1:0] er;
    logic [N_CH-1:0] erp;
    logic [4*N_CH-1:0] obs;
    logic [4*N_CH-1:0] expv;
    int i;
    ep  = '0;
    er  = '0;
    erp = '0;
    i   = 0;
    while (i < q.size()) begin
      if (q[i].at == cyc) begin
        if (q[i].kind == K_PRESS) begin
          ep[q[i].ch]        = 1'b1;
          erp[q[i].ch]       = 1'b1;
          exp_level[q[i].ch] = 1'b1;
        end else if (q[i].kind == K_REL) begin
          er[q[i].ch]        = 1'b1;
          exp_level[q[i].ch] = 1'b0;
        end else begin
          erp[q[i].ch] = 1'b1;
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
    obs  = {bif.level, bif.press, bif.rel, bif.rpt};
    expv = {exp_level, ep, er, erp};
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL outputs cyc=%0d observed lvl/prs/rel/rpt=%b expected=%b", cyc, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    logic [4*N_CH-1:0] obs;
    obs = {bif.level, bif.press, bif.rel, bif.rpt};
    n_vec++;
    assert (obs === '0) else begin
      n_miss++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, {4*N_CH{1'b0}});
    end
  endtask

  task automatic step(input logic tk);
    bif.tick = tk;
    @(posedge clk);
    cyc++;
    #1;
    bif.tick = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    bif.raw  = 2'b10;
    bif.tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    cyc   = 0;
    // Channel 1 idles high (active-low pin): nothing may fire at reset exit.
    idle(12);

    // Clean press and release.
    bif.raw[0] = 1'b1; push(DLY, 0, K_PRESS); idle(10);
    bif.raw[0] = 1'b0; push(DLY, 0, K_REL);   idle(10);

    // Four-sample glitch is rejected.
    bif.raw[0] = 1'b1; idle(4);
    bif.raw[0] = 1'b0; idle(12);

    // Shortest pulse that commits: CNT_MAX+2 sampled cycles.
    bif.raw[0] = 1'b1; push(DLY, 0, K_PRESS); idle(CNT_MAX + 2);
    bif.raw[0] = 1'b0; push(DLY, 0, K_REL);   idle(12);

    // Auto-repeat: first repeat on the 3rd tick, then every 2nd tick.
    bif.raw[0] = 1'b1; push(DLY, 0, K_PRESS); idle(DLY);
    for (int k = 1; k <= 8; k++) begin
      idle(9);
      if (k == 3 || k == 5 || k == 7) push(1, 0, K_RPT);
      step(1'b1);
    end

    // Release commit lands on a tick that would otherwise repeat.
    bif.raw[0] = 1'b0; push(DLY, 0, K_REL); idle(DLY - 1); step(1'b1); idle(4);

    // New press with a tick on the commit edge: that tick is not counted.
    bif.raw[0] = 1'b1; push(DLY, 0, K_PRESS); idle(DLY - 1); step(1'b1);
    for (int k = 1; k <= 3; k++) begin
      idle(4);
      if (k == 3) push(1, 0, K_RPT);
      step(1'b1);
    end
    bif.raw[0] = 1'b0; push(DLY, 0, K_REL); idle(10);

    // Independent channels, including same-cycle presses on both.
    bif.raw = 2'b01; push(DLY, 0, K_PRESS); push(DLY, 1, K_PRESS); idle(10);
    bif.raw[0] = 1'b0; push(DLY, 0, K_REL); idle(3);
    bif.raw[1] = 1'b1; push(DLY, 1, K_REL); idle(12);

    // Async reset while channel 0 is held in REPEAT.
    bif.raw[0] = 1'b1; push(DLY, 0, K_PRESS); idle(DLY);
    for (int k = 1; k <= 4; k++) begin
      idle(3);
      if (k == 3) push(1, 0, K_RPT);
      step(1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    exp_level  = '0;
    bif.raw[0] = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(12);

    n_vec++;
    assert (q.size() == 0) else begin
      n_miss++;
      $error("FAIL pending_events observed=%0d expected=0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
